fb_port_arbiter: RTL and testbench

//  Shares one single-port 12-bit pixel RAM between the VGA scan-out timing block and the drawing logic.
//  - Scan-out has absolute priority while it reads (rdn=0).
//  - Queued pixel writes and a full-screen clear engine drain only in blanking slots (rdn=1).
//  - Sits between the VGA timing block, the game/draw logic and the framebuffer RAM.

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_wr_fifo.sv | 45 ++++
 rtl/fb_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_fb_port_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer port arbiter.
// Addresses are {row, col} with a fixed 1024-pixel line stride.
package fb_pkg;

  localparam int PIX_W       = 12;
  localparam int ROW_W       = 9;
  localparam int COL_W       = 10;
  localparam int ADDR_W      = ROW_W + COL_W;
  localparam int ENTRY_W     = ROW_W + COL_W + PIX_W;
  localparam int FB_H_ACTIVE = 640;
  localparam int FB_V_ACTIVE = 480;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  typedef struct packed {
    logic [ROW_W-1:0] y;
    logic [COL_W-1:0] x;
    logic [PIX_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write-request FIFO; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate counter.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wr_entry_t push_data,
  input  logic      pop,
  output wr_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH);

  wr_entry_t      mem_q [DEPTH];
  logic [PW:0]    wptr_q, rptr_q;
  logic           do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign head    = mem_q[rptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads own the RAM while rdn=0;
// the clear engine and then queued pixel writes use blanking cycles.
//
// Write request handshake: a request transfers on a clock edge where
// wr_valid && wr_ready; wr_valid may be raised regardless of wr_ready,
// and out-of-frame requests transfer but are dropped.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int H_ACTIVE   = FB_H_ACTIVE,
  parameter int V_ACTIVE   = FB_V_ACTIVE
) (
  input  logic              vga_clk,
  input  logic              rst,
  input  logic              rdn,
  input  logic [ROW_W-1:0]  row_addr,
  input  logic [COL_W-1:0]  col_addr,
  output logic [PIX_W-1:0]  pix_out,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [COL_W-1:0]  wr_x,
  input  logic [ROW_W-1:0]  wr_y,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              clr_start,
  input  logic [PIX_W-1:0]  clr_color,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  output fb_state_e         dbg_state
);

  localparam logic [COL_W-1:0] H_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] V_LAST = ROW_W'(V_ACTIVE - 1);

  fb_state_e        state_q, state_d;
  logic [COL_W-1:0] cx_q, cx_d;
  logic [ROW_W-1:0] cy_q, cy_d;
  logic [PIX_W-1:0] color_q, color_d;

  wr_entry_t push_entry, head;
  logic      fifo_full, fifo_empty, fifo_push, fifo_pop, in_frame;

  assign in_frame   = ({1'b0, wr_x} < (COL_W + 1)'(H_ACTIVE)) &&
                      ({1'b0, wr_y} < (ROW_W + 1)'(V_ACTIVE));
  assign wr_ready   = !fifo_full;
  assign fifo_push  = wr_valid && wr_ready && in_frame;
  assign push_entry = '{y: wr_y, x: wr_x, data: wr_data};
  assign clr_busy   = (state_q == CLEAR);
  assign dbg_state  = state_q;

  fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (vga_clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      color_q <= color_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    color_d   = color_q;
    fifo_pop  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    pix_out   = '0;

    if (!rdn) begin
      ram_addr = {row_addr, col_addr};
      pix_out  = ram_rdata;
    end

    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cx_d    = '0;
          cy_d    = '0;
          color_d = clr_color;
        end else if (rdn && !fifo_empty) begin
          fifo_pop  = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = {head.y, head.x};
          ram_wdata = head.data;
        end
      end
      CLEAR: begin
        // Counters only move on blanking cycles, so scan-out pauses the sweep.
        if (rdn) begin
          ram_we    = 1'b1;
          ram_addr  = {cy_q, cx_q};
          ram_wdata = color_q;
          if (cx_q == H_LAST) begin
            cx_d = '0;
            if (cy_q == V_LAST) begin
              cy_d    = '0;
              state_d = IDLE;
            end else begin
              cy_d = cy_q + 1'b1;
            end
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are held quiet while reset is asserted.
    if (rst) begin
      fifo_pop  = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      pix_out   = '0;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter on a reduced 16x8 frame; every RAM
// write is matched in order against a queue of expected {addr, data}.
module tb_fb_port_arbiter;

  localparam int H = 16;
  localparam int V = 8;

  logic        clk = 1'b0;
  logic        rst, rdn, wr_valid, clr_start;
  logic [8:0]  row_addr, wr_y;
  logic [9:0]  col_addr, wr_x;
  logic [11:0] wr_data, clr_color, pix_out, ram_wdata, ram_rdata;
  logic        wr_ready, clr_busy, ram_we;
  logic [18:0] ram_addr;
  fb_pkg::fb_state_e dbg_state;

  logic [30:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  bit chk_last = 0;

  always #20 clk = ~clk;

  // RAM model: read data is a fixed scramble of the address.
  assign ram_rdata = ram_addr[11:0] ^ 12'h5A5;

  fb_port_arbiter #(.FIFO_DEPTH(16), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .vga_clk   (clk),
    .rst       (rst),
    .rdn       (rdn),
    .row_addr  (row_addr),
    .col_addr  (col_addr),
    .pix_out   (pix_out),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_data   (wr_data),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input int x, input int y, input logic [11:0] d);
    exp_q.push_back({y[8:0], x[9:0], d});
  endtask

  task automatic push(input int x, input int y, input logic [11:0] d);
    int guard = 0;
    while (!wr_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (!wr_ready) check("push_ready_timeout", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1;
    wr_x     = x[9:0];
    wr_y     = y[8:0];
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  // Monitor: every RAM write must be the next expected one, in a blanking slot.
  always @(negedge clk) begin
    logic [30:0] e;
    if (chk_last) begin
      chk_last = 0;
      check("busy_drop_after_last", 32'(clr_busy), 32'd0);
    end
    if (ram_we) begin
      wr_count++;
      check("we_only_in_blank", 32'(rdn), 32'd1);
      check("col_in_frame", 32'(ram_addr[9:0] < 10'(H)), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {1'b0, ram_addr, ram_wdata}, 32'h7fff_ffff);
      end else begin
        e = exp_q.pop_front();
        check("write_addr_data", {1'b0, ram_addr, ram_wdata}, {1'b0, e});
      end
      if (clr_busy && ram_addr == {9'(V - 1), 10'(H - 1)}) chk_last = 1;
    end
  end

  initial begin
    int base;
    int cyc;
    rst = 1'b1; rdn = 1'b0; wr_valid = 1'b0; clr_start = 1'b0;
    row_addr = 9'd3; col_addr = 10'd9;
    wr_x = '0; wr_y = '0; wr_data = '0; clr_color = '0;

    // Reset: outputs quiet even though scan-out is reading.
    tick();
    check("rst_pix_out", 32'(pix_out), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    tick();
    rst = 1'b0;
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_clr_busy", 32'(clr_busy), 32'd0);
    check("rst_state_idle", 32'(dbg_state), 32'(fb_pkg::IDLE));

    // Scan-out passthrough: {3,9} = 0x00C09, read data 0xC09^0x5A5 = 0x9AC.
    @(negedge clk);
    check("scan_addr", 32'(ram_addr), 32'h00C09);
    check("scan_pix", 32'(pix_out), 32'h9AC);
    check("scan_we", 32'(ram_we), 32'd0);
    tick();

    // Scan-out priority: queued write waits through 100 read cycles.
    exp_wr(5, 7, 12'hABC);
    push(5, 7, 12'hABC);
    for (int i = 0; i < 100; i++) tick();
    check("prio_we_held", 32'(ram_we), 32'd0);
    rdn = 1'b1;
    @(negedge clk);
    check("prio_we", 32'(ram_we), 32'd1);
    check("prio_addr", 32'(ram_addr), 32'h01C05);
    check("prio_wdata", 32'(ram_wdata), 32'hABC);
    check("blank_pix_zero", 32'(pix_out), 32'd0);
    tick();
    rdn = 1'b0;

    // Backpressure: 16 entries fill the FIFO, one blanking pop frees a slot.
    for (int i = 0; i < 16; i++) begin
      exp_wr(i, 1, 12'h100 + 12'(i));
      push(i, 1, 12'h100 + 12'(i));
    end
    check("full_not_ready", 32'(wr_ready), 32'd0);
    rdn = 1'b1;
    tick();
    rdn = 1'b0;
    check("pop_ready_again", 32'(wr_ready), 32'd1);
    rdn = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    rdn = 1'b0;
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    // Out-of-frame requests transfer but never reach the RAM.
    base = wr_count;
    push(H, 0, 12'h111);
    push(640, 2, 12'h112);
    push(1, V, 12'h113);
    exp_wr(2, 2, 12'h222);
    push(2, 2, 12'h222);
    check("oor_ready", 32'(wr_ready), 32'd1);
    rdn = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    rdn = 1'b0;
    check("oor_one_write", 32'(wr_count - base), 32'd1);

    // Clear with a pending FIFO write: clear runs first, then the entry.
    push(3, 3, 12'h333);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) exp_wr(x, y, 12'h0F0);
    exp_wr(3, 3, 12'h333);
    base = wr_count;
    clr_start = 1'b1; clr_color = 12'h0F0; rdn = 1'b1;
    tick();
    clr_start = 1'b0; clr_color = 12'h000;
    check("clr_busy_set", 32'(clr_busy), 32'd1);
    check("clr_state", 32'(dbg_state), 32'(fb_pkg::CLEAR));
    cyc = 0;
    while (clr_busy && cyc < 3000) begin
      rdn       = (cyc % 4 == 3);
      clr_start = (cyc == 10);
      clr_color = (cyc == 10) ? 12'hF00 : 12'h000;
      tick();
      cyc++;
    end
    rdn = 1'b0; clr_start = 1'b0;
    check("clr_done_in_budget", 32'(clr_busy), 32'd0);
    check("clr_write_count", 32'(wr_count - base), 32'(H * V));
    rdn = 1'b1;
    tick();
    tick();
    rdn = 1'b0;
    check("clr_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-clear aborts the sweep and drops the queued entry.
    push(4, 4, 12'h444);
    for (int i = 0; i < 50; i++) exp_wr(i % H, i / H, 12'h00F);
    base = wr_count;
    clr_start = 1'b1; clr_color = 12'h00F; rdn = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", 32'(clr_busy), 32'd0);
    check("rst_mid_ready", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 20; i++) tick();
    rdn = 1'b0;
    check("rst_mid_writes", 32'(wr_count - base), 32'd50);
    check("rst_mid_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
